// File: rtl/fifo_pkg.sv
// Shared types and defaults for the async FIFO read-side blocks.
// Optional FIFO_RD_STAT_EN statistics use STAT_W and sat_add.
package fifo_pkg;

    localparam int unsigned DATA_SIZE_DEF = 12;
    localparam int unsigned ADDR_SIZE_DEF = 4;
    localparam int unsigned STAT_W        = 16;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFlush,
        StDone
    } rd_state_e;

    function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a,
                                                  input logic [1:0]        inc);
        logic [STAT_W:0] sum;
        sum = {1'b0, a} + {{(STAT_W - 1){1'b0}}, inc};
        return sum[STAT_W] ? {STAT_W{1'b1}} : sum[STAT_W-1:0];
    endfunction

endpackage

// File: rtl/rd_skid_buf2.sv
// Two-entry in-order buffer: entry 0 is always the head, clear_i overrides push/pop.
module rd_skid_buf2
    import fifo_pkg::*;
#(
    parameter int unsigned Width = DATA_SIZE_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [Width-1:0] push_data_i,
    input  logic             pop_i,
    output logic [Width-1:0] head_o,
    output logic [1:0]       occ_o
);

    logic [Width-1:0] e0_q, e0_d;
    logic [Width-1:0] e1_q, e1_d;
    logic [1:0]       occ_q, occ_d;

    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        occ_d = occ_q;
        if (clear_i) begin
            occ_d = 2'd0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        e0_d = push_data_i;
                    end else begin
                        e1_d = push_data_i;
                    end
                    occ_d = occ_q + 2'd1;
                end
                2'b01: begin
                    e0_d  = e1_q;
                    occ_d = occ_q - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the incoming word lands behind whatever remains.
                    if (occ_q == 2'd2) begin
                        e0_d = e1_q;
                        e1_d = push_data_i;
                    end else begin
                        e0_d = push_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            e0_q  <= '0;
            e1_q  <= '0;
            occ_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            occ_q <= occ_d;
        end
    end

    assign head_o = e0_q;
    assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Async FIFO read port to valid/ready stream with enable gate and flush engine.
// Define FIFO_RD_STAT_EN to add the rd_words / drop_words counters.
module fifo_rd_stream_adapter
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_SIZE = DATA_SIZE_DEF
) (
    input  logic                 rclk,
    input  logic                 rrst,
    input  logic                 enable,
    input  logic                 flush_req,
    output logic                 flush_done,
    input  logic                 rEmpty,
    output logic                 rinc,
    input  logic [DATA_SIZE-1:0] rData,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [DATA_SIZE-1:0] m_data
`ifdef FIFO_RD_STAT_EN
    ,
    output logic [STAT_W-1:0]    rd_words,
    output logic [STAT_W-1:0]    drop_words
`endif
);

    rd_state_e            state_q;
    logic                 inflight_q;
    logic                 flush_armed_q;
    logic                 flush_done_q;

    logic [1:0]           occ;
    logic [DATA_SIZE-1:0] head;
    logic                 in_stream;
    logic                 pop_out;
    logic                 flush_start;
    logic                 buf_push;
    logic [2:0]           committed;

    assign in_stream   = (state_q == StIdle) || (state_q == StRun);
    assign m_valid     = in_stream && (occ != 2'd0);
    assign m_data      = head;
    assign pop_out     = m_valid && m_ready;
    assign flush_start = in_stream && flush_req && flush_armed_q;
    // A word landing in the flush-entry cycle is discarded together with the buffer.
    assign buf_push    = inflight_q && in_stream && !flush_start;
    assign committed   = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop_out};
    assign flush_done  = flush_done_q;

    always_comb begin
        rinc = 1'b0;
        unique case (state_q)
            StRun:   rinc = !rEmpty && (committed <= 3'd1);
            StFlush: rinc = !rEmpty;
            default: rinc = 1'b0;
        endcase
    end

    rd_skid_buf2 #(
        .Width (DATA_SIZE)
    ) u_buf (
        .clk_i       (rclk),
        .rst_i       (rrst),
        .clear_i     (flush_start),
        .push_i      (buf_push),
        .push_data_i (rData),
        .pop_i       (pop_out),
        .head_o      (head),
        .occ_o       (occ)
    );

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_q       <= StIdle;
            inflight_q    <= 1'b0;
            flush_armed_q <= 1'b1;
            flush_done_q  <= 1'b0;
        end else begin
            inflight_q   <= rinc;
            flush_done_q <= 1'b0;
            // A new flush needs flush_req to have been seen low since the last one.
            if (!flush_req) begin
                flush_armed_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (flush_start) begin
                        state_q       <= StFlush;
                        flush_armed_q <= 1'b0;
                    end else if (enable) begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (flush_start) begin
                        state_q       <= StFlush;
                        flush_armed_q <= 1'b0;
                    end else if (!enable) begin
                        state_q <= StIdle;
                    end
                end
                StFlush: begin
                    if (rEmpty && !inflight_q) begin
                        state_q      <= StDone;
                        flush_done_q <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef FIFO_RD_STAT_EN
    logic [1:0]        drop_inc;
    logic [STAT_W-1:0] rd_words_q;
    logic [STAT_W-1:0] drop_words_q;

    always_comb begin
        drop_inc = 2'd0;
        if (flush_start) begin
            drop_inc = occ - {1'b0, pop_out} + {1'b0, inflight_q};
        end else if ((state_q == StFlush) && inflight_q) begin
            drop_inc = 2'd1;
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            rd_words_q   <= '0;
            drop_words_q <= '0;
        end else begin
            rd_words_q   <= sat_add(rd_words_q, {1'b0, pop_out});
            drop_words_q <= sat_add(drop_words_q, drop_inc);
        end
    end

    assign rd_words   = rd_words_q;
    assign drop_words = drop_words_q;
`else
    // Statistics counters are not built.
`endif

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Scoreboard bench for fifo_rd_stream_adapter with a behavioural FIFO read port.
module tb_fifo_rd_stream_adapter;

    logic        rclk;
    logic        rrst;
    logic        enable;
    logic        flush_req;
    logic        flush_done;
    logic        rEmpty;
    logic        rinc;
    logic [11:0] rData;
    logic        m_valid;
    logic        m_ready;
    logic [11:0] m_data;
`ifdef FIFO_RD_STAT_EN
    logic [15:0] rd_words;
    logic [15:0] drop_words;
`endif

    logic        fifo_empty;
    logic        block_empty;
    logic [11:0] fifo_q[$];
    logic [11:0] pend_q[$];
    logic [11:0] exp_q[$];

    int n_tests;
    int n_fail;
    int cyc;
    int rinc_cnt;
    int done_cnt;
    int first_rinc_cyc;
    int last_rinc_cyc;
    int first_deliv_cyc;
    int last_deliv_cyc;
    logic        hold_prev;
    logic        flush_prev;
    logic [11:0] prev_data;

    assign rEmpty = fifo_empty | block_empty;

    fifo_rd_stream_adapter #(
        .DATA_SIZE (12)
    ) dut (
        .rclk       (rclk),
        .rrst       (rrst),
        .enable     (enable),
        .flush_req  (flush_req),
        .flush_done (flush_done),
        .rEmpty     (rEmpty),
        .rinc       (rinc),
        .rData      (rData),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data)
`ifdef FIFO_RD_STAT_EN
        ,
        .rd_words   (rd_words),
        .drop_words (drop_words)
`endif
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic load(input logic [11:0] first, input int n, input int n_exp);
        for (int i = 0; i < n; i++) begin
            pend_q.push_back(first + 12'(i));
            if (i < n_exp) exp_q.push_back(first + 12'(i));
        end
    endtask

    task automatic wait_drained(input int budget, input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk(name, exp_q.size(), 0);
        tick();
    endtask

    task automatic wait_done(input int base, input int budget, input string name);
        int n;
        n = 0;
        while (done_cnt == base && n < budget) begin
            tick();
            n++;
        end
        chk(name, (done_cnt > base) ? 1 : 0, 1);
    endtask

    // Behavioural FIFO: pop on rinc, rData valid the following cycle.
    always @(posedge rclk) begin
        cyc <= cyc + 1;
        if (rinc) begin
            chk("pop_while_empty", rEmpty, 1'b0);
            if (fifo_q.size() > 0) rData <= fifo_q.pop_front();
        end
        while (pend_q.size() > 0) fifo_q.push_back(pend_q.pop_front());
        fifo_empty <= (fifo_q.size() == 0);
    end

    // Monitor: scoreboard pop on each handshake plus hold-stability checks.
    always @(negedge rclk) begin
        if (!rrst) begin
            if (rinc) begin
                rinc_cnt++;
                if (first_rinc_cyc < 0) first_rinc_cyc = cyc;
                last_rinc_cyc = cyc;
            end
            if (flush_done) done_cnt++;
            if (hold_prev && !flush_prev) begin
                chk("hold_valid", m_valid, 1'b1);
                chk("hold_data", m_data, prev_data);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", m_data, 12'hfff ^ m_data);
                end else begin
                    chk("stream_data", m_data, exp_q.pop_front());
                end
                if (first_deliv_cyc < 0) first_deliv_cyc = cyc;
                last_deliv_cyc = cyc;
            end
            hold_prev  = m_valid && !m_ready;
            prev_data  = m_data;
            flush_prev = flush_req;
        end
    end

    initial begin
        int base;
        int n;
        n_tests = 0;
        n_fail = 0;
        cyc = 0;
        rinc_cnt = 0;
        done_cnt = 0;
        first_rinc_cyc = -1;
        last_rinc_cyc = -1;
        first_deliv_cyc = -1;
        last_deliv_cyc = -1;
        hold_prev = 1'b0;
        flush_prev = 1'b0;
        prev_data = '0;
        rData = '0;
        fifo_empty = 1'b1;
        block_empty = 1'b0;
        rrst = 1'b1;
        enable = 1'b0;
        flush_req = 1'b0;
        m_ready = 1'b0;

        // Words sit in the FIFO during reset so rEmpty is low.
        load(12'h001, 8, 8);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_rinc", rinc, 1'b0);
            chk("rst_m_valid", m_valid, 1'b0);
            chk("rst_m_data", m_data, 12'h000);
            chk("rst_flush_done", flush_done, 1'b0);
        end
        chk("rst_rempty_low", rEmpty, 1'b0);

        // Streaming at full rate.
        rrst = 1'b0;
        enable = 1'b1;
        m_ready = 1'b1;
        wait_drained(40, "stream_drain");
        chk("stream_pops", rinc_cnt, 8);
        chk("stream_rinc_consec", last_rinc_cyc - first_rinc_cyc, 7);
        chk("stream_latency", first_deliv_cyc - first_rinc_cyc, 2);
        chk("stream_out_consec", last_deliv_cyc - first_deliv_cyc, 7);

        // Backpressure: only two pops while the sink stalls.
        m_ready = 1'b0;
        base = rinc_cnt;
        load(12'h011, 5, 5);
        repeat (10) tick();
        chk("bp_pops", rinc_cnt - base, 2);
        chk("bp_valid", m_valid, 1'b1);
        chk("bp_data", m_data, 12'h011);
        m_ready = 1'b1;
        wait_drained(30, "bp_drain");
        chk("bp_fifo_empty", fifo_q.size(), 0);

        // Enable dropped in the pop cycle: only the in-flight word comes out.
        base = rinc_cnt;
        load(12'h021, 4, 1);
        n = 0;
        tick();
        while (!rinc && n < 10) begin
            tick();
            n++;
        end
        chk("en_rinc_seen", rinc, 1'b1);
        enable = 1'b0;
        repeat (6) tick();
        chk("en_pops", rinc_cnt - base, 1);
        chk("en_fifo_left", fifo_q.size(), 3);
        chk("en_delivered", exp_q.size(), 0);
        exp_q.push_back(12'h022);
        exp_q.push_back(12'h023);
        exp_q.push_back(12'h024);
        enable = 1'b1;
        wait_drained(20, "en_resume_drain");

        // rEmpty toggling every cycle.
        base = rinc_cnt;
        load(12'h031, 4, 4);
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            block_empty = ~block_empty;
            tick();
            n++;
        end
        block_empty = 1'b0;
        chk("tog_drain", exp_q.size(), 0);
        tick();
        chk("tog_pops", rinc_cnt - base, 4);

        // Flush with 2 buffered and 6 in the FIFO; enable also high.
        m_ready = 1'b0;
        load(12'h041, 8, 0);
        repeat (8) tick();
        chk("fl1_valid_before", m_valid, 1'b1);
        chk("fl1_head", m_data, 12'h041);
        chk("fl1_fifo_before", fifo_q.size(), 6);
        base = done_cnt;
        flush_req = 1'b1;
        tick();
        chk("fl1_abort_valid", m_valid, 1'b0);
        m_ready = 1'b1;
        repeat (2) tick();
        flush_req = 1'b0;
        wait_done(base, 30, "fl1_done_seen");
        repeat (3) tick();
        chk("fl1_done_pulses", done_cnt - base, 1);
        chk("fl1_fifo_after", fifo_q.size(), 0);
        chk("fl1_valid_after", m_valid, 1'b0);
`ifdef FIFO_RD_STAT_EN
        chk("fl1_drop_words", drop_words, 16'd8);
        chk("fl1_rd_words", rd_words, 16'd21);
`endif

        // Flush while the FIFO refills; flush_req held high throughout.
        enable = 1'b0;
        tick();
        load(12'h051, 3, 0);
        tick();
        base = done_cnt;
        flush_req = 1'b1;
        tick();
        load(12'h055, 4, 0);
        wait_done(base, 40, "fl2_done_seen");
        repeat (5) tick();
        chk("fl2_done_pulses", done_cnt - base, 1);
        flush_req = 1'b0;
        tick();
        chk("fl2_fifo_after", fifo_q.size(), 0);
        chk("fl2_valid_after", m_valid, 1'b0);
`ifdef FIFO_RD_STAT_EN
        chk("fl2_drop_words", drop_words, 16'd15);

        // Saturation of the delivered-word counter.
        enable = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            pend_q.push_back(12'(i));
            exp_q.push_back(12'(i));
        end
        wait_drained(70000, "sat_drain");
        chk("sat_rd_words", rd_words, 16'hffff);
        chk("sat_drop_words", drop_words, 16'd15);
`endif

        chk("final_scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
